// File: rtl/seg_pager_if.sv
// seg_pager_if: BCD input, load/hold controls and paged seven-segment outputs of the pager.
interface seg_pager_if #(
    parameter int NUM_DIGITS   = 9,
    parameter int NUM_DISPLAYS = 3
);
    localparam int NUM_PAGES = (NUM_DIGITS + NUM_DISPLAYS - 1) / NUM_DISPLAYS;
    localparam int PAGE_W    = $clog2(NUM_PAGES + 1);
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic                      load;
    logic                      hold;
    logic [7*NUM_DISPLAYS-1:0] a_to_g;
    logic [PAGE_W-1:0]         page;
    logic                      page_strobe;
    modport master (output digits_in, load, hold, input a_to_g, page, page_strobe);
    modport slave  (input digits_in, load, hold, output a_to_g, page, page_strobe);
endinterface

// File: rtl/seg_pager.sv
// seg_pager: snapshots a wide BCD value and pages it across a few seven-segment displays on a dwell timer.
module seg_pager #(
    parameter int NUM_DIGITS   = 9,
    parameter int NUM_DISPLAYS = 3,
    parameter int DWELL_CYCLES = 25_000_000,
    parameter int BLANK_PAGE   = 1,
    parameter int LZ_BLANK     = 0
) (
    input logic       CLOCK_50,
    input logic       reset_n,
    seg_pager_if.slave bus
);
    localparam int NUM_PAGES = (NUM_DIGITS + NUM_DISPLAYS - 1) / NUM_DISPLAYS;
    localparam int PAGE_W    = $clog2(NUM_PAGES + 1);
    localparam int CNT_W     = $clog2(DWELL_CYCLES);
    localparam int START     = (BLANK_PAGE != 0) ? NUM_PAGES : 0;

    logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [PAGE_W-1:0]         page_q, page_d, page_nx;
    logic                      strobe_q, strobe_d;
    logic [7*NUM_DISPLAYS-1:0] seg_q, seg_d;
    logic                      tc;
    int                        msnz;
    int                        idx;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign tc = cnt_q == CNT_W'(DWELL_CYCLES - 1);

    always_comb begin
        page_nx  = (page_q == PAGE_W'(NUM_PAGES)) ? '0 :
                   (page_q == PAGE_W'(NUM_PAGES - 1)) ? ((BLANK_PAGE != 0) ? PAGE_W'(NUM_PAGES) : '0) :
                   page_q + 1'b1;
        shadow_d = bus.load ? bus.digits_in : shadow_q;
        cnt_d    = bus.hold ? cnt_q : (tc ? '0 : cnt_q + 1'b1);
        page_d   = (!bus.hold && tc) ? page_nx : page_q;
        strobe_d = !bus.hold && tc;
    end

    // Highest non-zero digit bounds leading-zero blanking; an all-zero shadow keeps digit 0.
    always_comb begin
        msnz = 0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (shadow_q[4*i +: 4] != 4'd0) msnz = i;
    end

    always_comb begin
        seg_d = '1;
        idx   = 0;
        for (int d = 0; d < NUM_DISPLAYS; d++) begin
            idx = NUM_DIGITS - 1 - int'(page_q) * NUM_DISPLAYS - (NUM_DISPLAYS - 1 - d);
            if (page_q != PAGE_W'(NUM_PAGES) && idx >= 0 && !(LZ_BLANK != 0 && idx > msnz))
                seg_d[7*d +: 7] = decode(4'(shadow_q >> (4 * idx)));
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            page_q   <= PAGE_W'(START);
            strobe_q <= 1'b0;
            seg_q    <= '1;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            page_q   <= page_d;
            strobe_q <= strobe_d;
            seg_q    <= seg_d;
        end
    end

    assign bus.a_to_g      = seg_q;
    assign bus.page        = page_q;
    assign bus.page_strobe = strobe_q;
endmodule
